// File: rtl/updown_counter_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : updown_counter_sequencer
// Description : Run/stop/clear sequencer, direction register and tick
//               prescaler for the up/down counter datapath. Optional UART
//               command requester enabled by `define UART_CMD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module updown_counter_sequencer #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_run_stop,
    input  logic       btn_clear,
    input  logic       cmd_valid,
    input  logic [7:0] cmd_data,
    output logic       cmd_ready,
    output logic       cnt_tick,
    output logic       cnt_up,
    output logic       cnt_clear,
    output logic [1:0] led_mode,
    output logic [1:0] led_run_stop
);

    localparam int C_PERIOD = CLK_HZ / TICK_HZ;
    localparam int C_PW     = (C_PERIOD > 2) ? $clog2(C_PERIOD) : 1;
    localparam logic [C_PW-1:0] C_LAST = C_PW'(C_PERIOD - 1);

    localparam logic [7:0] C_BYTE_RUN_STOP = 8'h72;
    localparam logic [7:0] C_BYTE_CLEAR    = 8'h63;
    localparam logic [7:0] C_BYTE_MODE     = 8'h6D;

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic              r_mode_up;
    logic [C_PW-1:0]   r_presc;

    logic              w_btn_any;
    logic              w_uart_run_stop;
    logic              w_uart_clear;
    logic              w_uart_mode;
    logic              w_do_clear;
    logic              w_do_run_stop;
    logic              w_do_mode;

    assign w_btn_any = btn_mode | btn_run_stop | btn_clear;

`ifdef UART_CMD_EN
    logic w_uart_accept;

    // UART only wins a cycle in which no button pulse is present.
    assign cmd_ready       = ~w_btn_any;
    assign w_uart_accept   = cmd_valid & cmd_ready;
    assign w_uart_run_stop = w_uart_accept & (cmd_data == C_BYTE_RUN_STOP);
    assign w_uart_clear    = w_uart_accept & (cmd_data == C_BYTE_CLEAR);
    assign w_uart_mode     = w_uart_accept & (cmd_data == C_BYTE_MODE);
`else
    logic w_unused_cmd;

    assign cmd_ready       = 1'b1;
    assign w_unused_cmd    = ^{cmd_valid, cmd_data, C_BYTE_RUN_STOP,
                               C_BYTE_CLEAR, C_BYTE_MODE};
    assign w_uart_run_stop = 1'b0;
    assign w_uart_clear    = 1'b0;
    assign w_uart_mode     = 1'b0;
`endif

    // Single honoured command per cycle, buttons ahead of UART.
    always_comb begin
        w_do_clear    = 1'b0;
        w_do_run_stop = 1'b0;
        w_do_mode     = 1'b0;
        if (btn_clear) begin
            w_do_clear = 1'b1;
        end else if (btn_run_stop) begin
            w_do_run_stop = 1'b1;
        end else if (btn_mode) begin
            w_do_mode = 1'b1;
        end else begin
            w_do_clear    = w_uart_clear;
            w_do_run_stop = w_uart_run_stop;
            w_do_mode     = w_uart_mode;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_STOP;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_STOP: begin
                if (w_do_clear) begin
                    w_state_next = ST_CLEAR;
                end else if (w_do_run_stop) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_do_clear) begin
                    w_state_next = ST_CLEAR;
                end else if (w_do_run_stop) begin
                    w_state_next = ST_STOP;
                end
            end
            ST_CLEAR: begin
                w_state_next = w_do_clear ? ST_CLEAR : ST_STOP;
            end
            default: begin
                w_state_next = ST_STOP;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mode_up <= 1'b1;
        end else if (w_do_mode) begin
            r_mode_up <= ~r_mode_up;
        end
    end

    // Counts only while staying in RUN, so STOP and CLEAR always see zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_presc <= '0;
        end else if ((r_state == ST_RUN) && (w_state_next == ST_RUN)) begin
            r_presc <= (r_presc == C_LAST) ? '0 : r_presc + 1'b1;
        end else begin
            r_presc <= '0;
        end
    end

    assign cnt_tick     = (r_state == ST_RUN) && (r_presc == C_LAST);
    assign cnt_clear    = (r_state == ST_CLEAR);
    assign cnt_up       = r_mode_up;
    assign led_mode     = {~r_mode_up, r_mode_up};
    assign led_run_stop = {r_state == ST_RUN, r_state != ST_RUN};

endmodule
`default_nettype wire
